// File: rtl/ae_frame_gen_if.sv
// Streaming RGB pixel bus between the frame source and its consumers.
// The master drives the data and the sync qualifiers.
interface ae_frame_gen_if #(
   parameter int rgb_width = 8
);
   logic [rgb_width-1:0] rgb_r;
   logic [rgb_width-1:0] rgb_g;
   logic [rgb_width-1:0] rgb_b;
   logic                 rgb_vsync;
   logic                 rgb_valid;

   modport master (
      output rgb_r, rgb_g, rgb_b,
      output rgb_vsync, rgb_valid
   );

   modport slave (
      input rgb_r, rgb_g, rgb_b,
      input rgb_vsync, rgb_valid
   );
endinterface

// File: rtl/ae_frame_gen.sv
// Synthetic RGB frame source with programmable sync/blanking timing.
// Emits flat, ramp and checker test patterns on the pixel stream bus.
module ae_frame_gen #(
   parameter int rgb_width        = 8,
   parameter int resolution_long  = 1280,
   parameter int resolution_width = 720,
   parameter int h_blank          = 16,
   parameter int v_blank          = 32,
   parameter int vsync_len        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [7:0]           num_frames,
   input  logic [1:0]           pattern_sel,
   input  logic [rgb_width-1:0] flat_r,
   input  logic [rgb_width-1:0] flat_g,
   input  logic [rgb_width-1:0] flat_b,
   ae_frame_gen_if.master       pix,
   output logic                 frame_done,
   output logic                 busy,
   output logic [15:0]          frame_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_VBP,
      S_ACTIVE,
      S_HBLANK,
      S_END
   } state_t;

   localparam logic [15:0] LAST_X  = 16'(resolution_long - 1);
   localparam logic [15:0] LAST_Y  = 16'(resolution_width - 1);
   localparam logic [15:0] VS_LAST = 16'(vsync_len - 1);
   localparam logic [15:0] VB_LAST = 16'(v_blank - 1);
   localparam logic [15:0] HB_LAST = 16'(h_blank - 1);
   localparam bit          HB_SKIP = (h_blank == 0);

   state_t state, state_nx;
   logic [15:0] cnt, cnt_nx;
   logic [15:0] x, x_nx;
   logic [15:0] y, y_nx;
   logic [7:0]  rem, rem_nx;
   logic        counted, counted_nx;
   logic        stop_pend, stop_pend_nx;
   logic        lat;

   logic [1:0]           pat;
   logic [rgb_width-1:0] fr, fg, fb;
   logic [rgb_width-1:0] px_r, px_g, px_b;

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      x_nx         = x;
      y_nx         = y;
      rem_nx       = rem;
      counted_nx   = counted;
      stop_pend_nx = stop_pend;
      if (state != S_IDLE && stop)
         stop_pend_nx = 1'b1;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nx     = S_VSYNC;
               cnt_nx       = '0;
               rem_nx       = num_frames;
               counted_nx   = (num_frames != 8'd0);
               stop_pend_nx = 1'b0;
            end
         end
         S_VSYNC: begin
            if (cnt == VS_LAST) begin
               state_nx = S_VBP;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_VBP: begin
            if (cnt == VB_LAST) begin
               state_nx = S_ACTIVE;
               x_nx     = '0;
               y_nx     = '0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_ACTIVE: begin
            if (x == LAST_X) begin
               x_nx = '0;
               if (y == LAST_Y) begin
                  state_nx = S_END;
               end else if (HB_SKIP) begin
                  y_nx = y + 16'd1;
               end else begin
                  state_nx = S_HBLANK;
                  cnt_nx   = '0;
               end
            end else begin
               x_nx = x + 16'd1;
            end
         end
         S_HBLANK: begin
            if (cnt == HB_LAST) begin
               state_nx = S_ACTIVE;
               y_nx     = y + 16'd1;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_END: begin
            cnt_nx = '0;
            if (counted)
               rem_nx = rem - 8'd1;
            // a stop arriving in this very cycle still ends the run here
            if (stop_pend_nx || (counted && rem == 8'd1)) begin
               state_nx     = S_IDLE;
               stop_pend_nx = 1'b0;
            end else begin
               state_nx = S_VSYNC;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign lat = (state_nx == S_VSYNC) && (state != S_VSYNC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         x         <= '0;
         y         <= '0;
         rem       <= '0;
         counted   <= 1'b0;
         stop_pend <= 1'b0;
         pat       <= '0;
         fr        <= '0;
         fg        <= '0;
         fb        <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         x         <= x_nx;
         y         <= y_nx;
         rem       <= rem_nx;
         counted   <= counted_nx;
         stop_pend <= stop_pend_nx;
         if (lat) begin
            pat <= pattern_sel;
            fr  <= flat_r;
            fg  <= flat_g;
            fb  <= flat_b;
         end
      end
   end

   always_comb begin
      px_r = '0;
      px_g = '0;
      px_b = '0;
      unique case (pat)
         2'd0: begin
            px_r = fr;
            px_g = fg;
            px_b = fb;
         end
         2'd1: begin
            px_r = x[rgb_width-1:0];
            px_g = x[rgb_width-1:0];
            px_b = x[rgb_width-1:0];
         end
         2'd2: begin
            px_r = y[rgb_width-1:0];
            px_g = y[rgb_width-1:0];
            px_b = y[rgb_width-1:0];
         end
         2'd3: begin
            px_r = {rgb_width{x[5] ^ y[5]}};
            px_g = {rgb_width{x[5] ^ y[5]}};
            px_b = {rgb_width{x[5] ^ y[5]}};
         end
         default: ;
      endcase
   end

   // outputs trail the state by one cycle so every port is a flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix.rgb_r     <= '0;
         pix.rgb_g     <= '0;
         pix.rgb_b     <= '0;
         pix.rgb_vsync <= 1'b0;
         pix.rgb_valid <= 1'b0;
         frame_done    <= 1'b0;
         busy          <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         pix.rgb_valid <= (state == S_ACTIVE);
         pix.rgb_vsync <= (state == S_VBP) ||
                          (state == S_ACTIVE) ||
                          (state == S_HBLANK);
         pix.rgb_r     <= (state == S_ACTIVE) ? px_r : '0;
         pix.rgb_g     <= (state == S_ACTIVE) ? px_g : '0;
         pix.rgb_b     <= (state == S_ACTIVE) ? px_b : '0;
         frame_done    <= (state == S_END);
         busy          <= (state != S_IDLE);
         if (state == S_END)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ae_frame_gen.sv
// Directed bench for ae_frame_gen: timing, patterns, stop/start rules,
// mid-frame reset, ramp wrap and a 64x64 checker checksum.
module tb_ae_frame_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       a_start = 1'b0, a_stop = 1'b0;
   logic [7:0] a_num = '0;
   logic [1:0] a_pat = '0;
   logic [7:0] a_fr = '0, a_fg = '0, a_fb = '0;
   logic       a_done, a_busy;
   logic [15:0] a_cnt;
   ae_frame_gen_if #(.rgb_width(8)) a_if ();

   ae_frame_gen #(
      .rgb_width(8), .resolution_long(8), .resolution_width(4),
      .h_blank(2), .v_blank(3), .vsync_len(2)
   ) u_a (
      .clk(clk), .rst(rst), .start(a_start), .stop(a_stop),
      .num_frames(a_num), .pattern_sel(a_pat),
      .flat_r(a_fr), .flat_g(a_fg), .flat_b(a_fb),
      .pix(a_if), .frame_done(a_done), .busy(a_busy),
      .frame_cnt(a_cnt)
   );

   logic       b_start = 1'b0;
   logic       b_done, b_busy;
   logic [15:0] b_cnt;
   ae_frame_gen_if #(.rgb_width(8)) b_if ();

   ae_frame_gen #(
      .rgb_width(8), .resolution_long(300), .resolution_width(2),
      .h_blank(0), .v_blank(1), .vsync_len(1)
   ) u_b (
      .clk(clk), .rst(rst), .start(b_start), .stop(1'b0),
      .num_frames(8'd1), .pattern_sel(2'd1),
      .flat_r(8'd0), .flat_g(8'd0), .flat_b(8'd0),
      .pix(b_if), .frame_done(b_done), .busy(b_busy),
      .frame_cnt(b_cnt)
   );

   logic       c_start = 1'b0;
   logic       c_done, c_busy;
   logic [15:0] c_cnt;
   ae_frame_gen_if #(.rgb_width(8)) c_if ();

   ae_frame_gen #(
      .rgb_width(8), .resolution_long(64), .resolution_width(64),
      .h_blank(2), .v_blank(3), .vsync_len(2)
   ) u_c (
      .clk(clk), .rst(rst), .start(c_start), .stop(1'b0),
      .num_frames(8'd1), .pattern_sel(2'd3),
      .flat_r(8'd0), .flat_g(8'd0), .flat_b(8'd0),
      .pix(c_if), .frame_done(c_done), .busy(c_busy),
      .frame_cnt(c_cnt)
   );

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {busy, vsync, valid, done, r, g, b} for cycle c after the start edge
   function automatic logic [27:0] exp_a(int c, int nfr, int p0, int p1,
                                         logic [7:0] fr, logic [7:0] fg,
                                         logic [7:0] fb);
      int n, m, x, y, pat;
      logic vs, vl, dn;
      logic [7:0] r, g, b;
      if (c > 44 * nfr) return '0;
      n  = c % 44;
      dn = (n == 0);
      vs = (n >= 3) && (n <= 43);
      m  = n - 6;
      vl = (m >= 0) && (m < 40) && ((m % 10) < 8);
      x  = vl ? m % 10 : 0;
      y  = vl ? m / 10 : 0;
      pat = (c < 44) ? p0 : p1;
      r = '0; g = '0; b = '0;
      if (vl) begin
         case (pat)
            0: begin r = fr; g = fg; b = fb; end
            1: begin r = 8'(x); g = 8'(x); b = 8'(x); end
            2: begin r = 8'(y); g = 8'(y); b = 8'(y); end
            default: begin
               r = (((x / 32) + (y / 32)) % 2 == 1) ? 8'd255 : 8'd0;
               g = r; b = r;
            end
         endcase
      end
      return {1'b1, vs, vl, dn, r, g, b};
   endfunction

   function automatic logic [27:0] obs_a();
      return {a_busy, a_if.rgb_vsync, a_if.rgb_valid, a_done,
              a_if.rgb_r, a_if.rgb_g, a_if.rgb_b};
   endfunction

   task automatic start_a(input logic [7:0] num, input logic [1:0] pat,
                          input logic [7:0] fr, input logic [7:0] fg,
                          input logic [7:0] fb);
      a_num = num; a_pat = pat;
      a_fr = fr; a_fg = fg; a_fb = fb;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   task automatic run_a(input string tag, input int nfr, input int len,
                        input int p0, input int p1,
                        input int stop_at, input int poke_at);
      int dones = 0;
      for (int c = 1; c <= len; c++) begin
         a_stop = (c == stop_at);
         if (c == poke_at) begin
            a_start = 1'b1;
            a_num   = 8'd7;
            a_pat   = 2'(p1);
         end
         tick();
         a_start = 1'b0;
         a_stop  = 1'b0;
         if (a_done) dones++;
         check($sformatf("%s c%0d", tag, c), 64'(obs_a()),
               64'(exp_a(c, nfr, p0, p1, a_fr, a_fg, a_fb)));
      end
      check({tag, " dones"}, 64'(dones), 64'(nfr));
   endtask

   initial begin
      int dones, sum, npx, m, x, y;
      logic vl;
      logic [7:0] e;

      repeat (3) tick();
      check("rst_a", 64'({obs_a(), a_cnt}), 64'(0));
      check("rst_bc", 64'({b_busy, b_done, b_cnt, c_busy, c_done, c_cnt}),
            64'(0));
      rst = 1'b0;
      tick();

      start_a(8'd1, 2'd0, 8'd30, 8'd30, 8'd30);
      run_a("flat", 1, 46, 0, 0, -1, -1);
      check("flat cnt", 64'(a_cnt), 64'(1));

      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      tick();
      check("idle stop busy", 64'(a_busy), 64'(0));
      a_stop = 1'b1;
      start_a(8'd2, 2'd0, 8'd10, 8'd20, 8'd30);
      a_stop = 1'b0;
      run_a("startstop", 2, 92, 0, 0, -1, -1);
      check("startstop cnt", 64'(a_cnt), 64'(3));

      start_a(8'd0, 2'd2, 8'd0, 8'd0, 8'd0);
      run_a("contstop", 2, 100, 2, 2, 60, -1);
      check("contstop cnt", 64'(a_cnt), 64'(5));

      start_a(8'd3, 2'd1, 8'd0, 8'd0, 8'd0);
      run_a("busystart", 3, 140, 1, 2, -1, 20);
      check("busystart cnt", 64'(a_cnt), 64'(8));

      start_a(8'd1, 2'd0, 8'd30, 8'd30, 8'd30);
      repeat (27) tick();
      check("pre_rst valid", 64'(a_if.rgb_valid), 64'(1));
      #2 rst = 1'b1;
      #1 check("mid_rst", 64'({obs_a(), a_cnt}), 64'(0));
      tick();
      check("rst held", 64'({obs_a(), a_cnt}), 64'(0));
      #2 rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (a_done || a_busy) dones++;
      end
      check("post_rst quiet", 64'(dones), 64'(0));
      start_a(8'd1, 2'd0, 8'd30, 8'd30, 8'd30);
      run_a("after_rst", 1, 46, 0, 0, -1, -1);
      check("after_rst cnt", 64'(a_cnt), 64'(1));

      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      dones = 0;
      for (int c = 1; c <= 604; c++) begin
         tick();
         m  = c - 3;
         vl = (m >= 0) && (m < 600);
         e  = vl ? 8'(m % 300) : 8'd0;
         if (b_done) dones++;
         check($sformatf("hramp c%0d", c),
               64'({b_if.rgb_vsync, b_if.rgb_valid, b_done,
                    b_if.rgb_r, b_if.rgb_g, b_if.rgb_b}),
               64'({(c >= 2) && (c <= 602), vl, c == 603, e, e, e}));
         if (c == 258) check("hramp x255", 64'(b_if.rgb_r), 64'(255));
         if (c == 259) check("hramp x256", 64'(b_if.rgb_r), 64'(0));
      end
      check("hramp dones", 64'(dones), 64'(1));

      c_start = 1'b1;
      tick();
      c_start = 1'b0;
      sum = 0; npx = 0; dones = 0;
      for (int c = 1; c <= 4229; c++) begin
         tick();
         m  = c - 6;
         y  = (m >= 0) ? m / 66 : 0;
         x  = (m >= 0) ? m % 66 : 0;
         vl = (m >= 0) && (y < 64) && (x < 64);
         e  = (vl && (((x >= 32) ? 1 : 0) != ((y >= 32) ? 1 : 0)))
              ? 8'd255 : 8'd0;
         if (c_if.rgb_valid) begin
            npx++;
            sum += int'(c_if.rgb_r) + int'(c_if.rgb_g) + int'(c_if.rgb_b);
         end
         if (c_done) dones++;
         check($sformatf("checker c%0d", c),
               64'({c_if.rgb_valid, c_if.rgb_r, c_if.rgb_g, c_if.rgb_b}),
               64'({vl, e, e, e}));
         if (c == 6)
            check("chk (0,0)", 64'(c_if.rgb_r), 64'(0));
         if (c == 6 + 32)
            check("chk (32,0)", 64'(c_if.rgb_r), 64'(255));
         if (c == 6 + 32 * 66 + 32)
            check("chk (32,32)", 64'(c_if.rgb_r), 64'(0));
         if (c == 4228)
            check("chk done", 64'(c_done), 64'(1));
      end
      check("chk pixels", 64'(npx), 64'(4096));
      check("chk sum", 64'(sum), 64'(1566720));
      check("chk dones", 64'(dones), 64'(1));
      check("chk cnt", 64'(c_cnt), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ae_frame_gen.md
# ae_frame_gen

Synthetic RGB frame source that drives the streaming pixel interface consumed by the AE histogram block (`rgb_r/g/b`, `rgb_vsync`, `rgb_valid`). It produces full-resolution frames with programmable sync and blanking timing, and one of four test patterns. Its purposes are AE bring-up on hardware without a sensor and a cycle-exact stimulus source for the ISP benches.

## Interface
- `rgb_width`, 8: pixel component width.
- `resolution_long`, 1280: active pixels per line (L).
- `resolution_width`, 720: active lines per frame (W).
- `h_blank`, 16: idle cycles between lines, `rgb_valid`=0; 0 allowed.
- `v_blank`, 32: cycles with `rgb_vsync`=1 before the first pixel; must be ≥1.
- `vsync_len`, 8: cycles with `rgb_vsync`=0 at frame start; must be ≥1.

Ports:
- `clk`  in  1: single clock. All outputs are registered on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request; accepted only in IDLE.
- `stop`  in  1: one-cycle request; finish the current frame, then go to IDLE.
- `num_frames`  in  8: frame count for the run; 0 = continuous until `stop`.
- `pattern_sel`  in  2: 0 flat, 1 horizontal ramp, 2 vertical ramp, 3 checker.
- `flat_r`, `flat_g`, `flat_b`  in  rgb_width: flat-pattern colour.
- `rgb_r`, `rgb_g`, `rgb_b`  out  rgb_width: pixel data; 0 whenever `rgb_valid`=0.
- `rgb_vsync`  out  1: frame envelope. A rising edge marks the frame start.
- `rgb_valid`  out  1: qualifies pixel data.
- `frame_done`  out  1: one-cycle pulse after the last pixel of each frame.
- `busy`  out  1: high in every state except IDLE.
- `frame_cnt`  out  16: completed frames since reset; wraps.

## Operation
- States: IDLE → VSYNC → VBP → ACTIVE ⇄ HBLANK → END → (VSYNC | IDLE).

State behaviour:
- **IDLE:** all outputs 0 except `frame_cnt`. `start` loads the remaining-frames counter from `num_frames` and moves to VSYNC.
- **VSYNC:** `vsync_len` cycles, `rgb_vsync`=0. On entry, latch `pattern_sel` and `flat_*`; they are held constant for the whole frame.
- **VBP:** `v_blank` cycles, `rgb_vsync`=1, `rgb_valid`=0.
- **ACTIVE:** L cycles, `rgb_valid`=1, x = 0..L-1. After the last pixel:
  - go to HBLANK if y < W-1;
  - go to END on the last line.
  - If `h_blank`=0, skip HBLANK; the next line follows with no gap.
- **HBLANK:** `h_blank` cycles, `rgb_valid`=0, `rgb_vsync`=1, then y increments.
- **END:** 1 cycle with `rgb_vsync`=0 and `frame_done`=1; `frame_cnt` increments. Then:
  - go to IDLE if a stop is pending, or if `num_frames` ≠ 0 and the remaining count reaches 0;
  - otherwise go to VSYNC.

Patterns (x, y are 16-bit active-area counters; M = 2^rgb_width − 1):
- 0 flat: (`flat_r`, `flat_g`, `flat_b`).
- 1 horizontal ramp: r=g=b=x[rgb_width-1:0], wrapping every 2^rgb_width pixels.
- 2 vertical ramp: r=g=b=y[rgb_width-1:0].
- 3 checker: r=g=b=M if x[5]^y[5], else 0 (32×32 tiles).

Boundary rules:
- `start` while `busy`: ignored; the loaded count is unchanged.
- `stop` in IDLE: ignored.
- `stop` in any other state: sets a sticky pending flag that is honoured at END. The current frame always completes with the full W×L pixels.
- `start` and `stop` in the same IDLE cycle: start wins and the stop is dropped.
- `rst` asserted mid-frame: every output goes to 0 immediately (including `frame_cnt`), the state goes to IDLE, and no partial `frame_done` is generated.

## Timing
- `start` sampled high at edge t: `rgb_vsync` is 0 for cycles t+1..t+`vsync_len`; it rises at t+1+`vsync_len`.
- First pixel at t+1+`vsync_len`+`v_blank`.
- Line period is L+`h_blank`. Line k starts `k·(L+h_blank)` after the first pixel.
- `frame_done` comes on the cycle after the last pixel. In that same cycle `rgb_vsync` falls.
- Frame period in a continuous run: `vsync_len`+`v_blank`+W·L+(W−1)·`h_blank`+1.
- Changes to `pattern_sel` or `flat_*` take effect only at the next VSYNC entry.

## Test plan
All scenarios use small parameters: L=8, W=4, h_blank=2, v_blank=3, vsync_len=2.

1. Flat, single frame: `start` at t, `num_frames`=1, flat=(30,30,30).
   - `rgb_vsync` rises at t+3.
   - Pixels at t+6..13, t+16..23, t+26..33, t+36..43, all (30,30,30): 32 valid pixels total.
   - `frame_done` at t+44; IDLE at t+45; `frame_cnt`=1.
2. Horizontal ramp: each line carries values 0..7.
   - With L=300, x=256 yields 0 (wrap check).
3. Continuous run with stop: `num_frames`=0, `stop` pulsed mid-frame 2.
   - Frame 2 completes with 32 pixels.
   - Exactly 2 `frame_done` pulses; `busy` falls after END.
   - The next VSYNC follows END with no gap between frames.
4. `start` while busy:
   - Ignored; the run length stays at the original `num_frames`=3 (3 pulses).
   - `pattern_sel` changed mid-frame applies only from the next frame.
5. Reset mid-frame: `rst` at line 2.
   - All outputs read 0 on the next cycle, `frame_cnt`=0, no `frame_done`.
   - A new `start` then produces a normal frame.
6. Checker with W=L=64:
   - Pixel (0,0)=0, (32,0)=255, (32,32)=0.
   - Checksum matches the reference model.
